pcm_to_i2s_tx: RTL and testbench

//  I2S transmitter: serialises one stereo PCM pair per frame onto sd, generating sck and ws from clk.

---
 rtl/pcm_to_i2s_tx_pkg.sv | 19 +
 rtl/pcm_to_i2s_tx_clkgen.sv | 43 ++++
 rtl/pcm_to_i2s_tx.sv | 142 ++++++++++++++
 tb/tb_pcm_to_i2s_tx.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcm_to_i2s_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pcm_to_i2s_tx_pkg
// Brief   : Shared defaults and FSM state encoding for the I2S transmitter.
// Revision: 1.0 - initial release
// ============================================================================
package pcm_to_i2s_tx_pkg;

    localparam int NUMBER_OF_BITS = 16;
    localparam int SLOT_BITS      = 32;
    localparam int CLK_DIV        = 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pcm_to_i2s_tx_clkgen.sv
`default_nettype none
// ============================================================================
// Module  : pcm_to_i2s_tx_clkgen
// Brief   : Divides clk down to the I2S bit clock and strobes each sck fall.
// Revision: 1.0 - initial release
// ============================================================================
module pcm_to_i2s_tx_clkgen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    output logic o_sck,
    output logic o_fall
);

    localparam int c_dw = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_dw-1:0] c_div_last = c_dw'(CLK_DIV - 1);

    logic [c_dw-1:0] r_div_cnt;
    logic            r_sck;
    logic            w_tick;

    assign w_tick = i_run && (r_div_cnt == c_div_last);

    // The fall strobe coincides with the clk edge that drives sck low.
    assign o_fall = w_tick && r_sck;
    assign o_sck  = r_sck;

    always_ff @(posedge clk) begin
        if (reset || !i_run) begin
            r_div_cnt <= '0;
            r_sck     <= 1'b0;
        end else if (w_tick) begin
            r_div_cnt <= '0;
            r_sck     <= ~r_sck;
        end else begin
            r_div_cnt <= r_div_cnt + c_dw'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/pcm_to_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module  : pcm_to_i2s_tx
// Brief   : I2S transmitter; serialises one buffered stereo PCM pair per frame.
// Revision: 1.0 - initial release
// ============================================================================
module pcm_to_i2s_tx #(
    parameter int NUMBER_OF_BITS = pcm_to_i2s_tx_pkg::NUMBER_OF_BITS,
    parameter int SLOT_BITS      = pcm_to_i2s_tx_pkg::SLOT_BITS,
    parameter int CLK_DIV        = pcm_to_i2s_tx_pkg::CLK_DIV
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUMBER_OF_BITS-1:0] in_left,
    input  logic [NUMBER_OF_BITS-1:0] in_right,
    output logic                      sck,
    output logic                      ws,
    output logic                      sd,
    output logic                      underrun,
    output logic                      busy
);

    import pcm_to_i2s_tx_pkg::*;

    localparam int c_cw = $clog2(2 * SLOT_BITS);
    localparam logic [c_cw-1:0] c_last  = c_cw'(2 * SLOT_BITS - 1);
    localparam logic [c_cw-1:0] c_slot  = c_cw'(SLOT_BITS);
    localparam logic [c_cw-1:0] c_nbits = c_cw'(NUMBER_OF_BITS);

    state_t                    r_state;
    logic [c_cw-1:0]           r_bit_cnt;
    logic                      r_ws;
    logic                      r_sd;
    logic                      r_underrun;
    logic                      r_hold_empty;
    logic [NUMBER_OF_BITS-1:0] r_hold_l;
    logic [NUMBER_OF_BITS-1:0] r_hold_r;
    logic [NUMBER_OF_BITS-1:0] r_sh_l;
    logic [NUMBER_OF_BITS-1:0] r_sh_r;

    logic            w_fall;
    logic            w_wrap;
    logic [c_cw-1:0] w_next;
    logic            w_next_right;
    logic [c_cw-1:0] w_pos;
    logic            w_data_bit;
    logic            w_xfer;

    pcm_to_i2s_tx_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk    (clk),
        .reset  (reset),
        .i_run  (r_state == ST_RUN),
        .o_sck  (sck),
        .o_fall (w_fall)
    );

    assign w_wrap       = (r_bit_cnt == c_last);
    assign w_next       = w_wrap ? '0 : r_bit_cnt + c_cw'(1);
    assign w_next_right = (w_next >= c_slot);
    assign w_pos        = w_next_right ? (w_next - c_slot) : w_next;
    // Slot position 0 is the I2S one-bit delay; positions past the sample are padding.
    assign w_data_bit   = (w_pos != '0) && (w_pos <= c_nbits);
    assign w_xfer       = in_valid && r_hold_empty;

    assign in_ready = r_hold_empty;
    assign ws       = r_ws;
    assign sd       = r_sd;
    assign underrun = r_underrun;
    assign busy     = (r_state == ST_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_bit_cnt    <= c_last;
            r_ws         <= 1'b1;
            r_sd         <= 1'b0;
            r_underrun   <= 1'b0;
            r_hold_empty <= 1'b1;
            r_hold_l     <= '0;
            r_hold_r     <= '0;
            r_sh_l       <= '0;
            r_sh_r       <= '0;
        end else begin
            r_underrun <= 1'b0;
            if (w_xfer) begin
                r_hold_l     <= in_left;
                r_hold_r     <= in_right;
                r_hold_empty <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    if (w_fall) begin
                        if (w_wrap && !enable) begin
                            r_state   <= ST_IDLE;
                            r_bit_cnt <= c_last;
                            r_ws      <= 1'b1;
                            r_sd      <= 1'b0;
                        end else begin
                            r_bit_cnt <= w_next;
                            r_ws      <= w_next_right;
                            if (w_wrap) begin
                                // Unload cannot collide with a transfer: it needs a full register.
                                if (!r_hold_empty) begin
                                    r_sh_l       <= r_hold_l;
                                    r_sh_r       <= r_hold_r;
                                    r_hold_empty <= 1'b1;
                                end else begin
                                    r_sh_l     <= '0;
                                    r_sh_r     <= '0;
                                    r_underrun <= 1'b1;
                                end
                                r_sd <= 1'b0;
                            end else if (w_data_bit) begin
                                if (w_next_right) begin
                                    r_sd   <= r_sh_r[NUMBER_OF_BITS-1];
                                    r_sh_r <= r_sh_r << 1;
                                end else begin
                                    r_sd   <= r_sh_l[NUMBER_OF_BITS-1];
                                    r_sh_l <= r_sh_l << 1;
                                end
                            end else begin
                                r_sd <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pcm_to_i2s_tx.sv
`default_nettype none
// ============================================================================
// Module  : tb_pcm_to_i2s_tx
// Brief   : Self-checking bench: I2S receiver model decodes sd and checks frames.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pcm_to_i2s_tx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        en_a = 0, valid_a = 0, ready_a, sck_a, ws_a, sd_a, un_a, busy_a;
    logic [15:0] l_a = 0, r_a = 0;
    logic        en_b = 0, valid_b = 0, ready_b, sck_b, ws_b, sd_b, un_b, busy_b;
    logic [15:0] l_b = 0, r_b = 0;

    pcm_to_i2s_tx #(.NUMBER_OF_BITS(16), .SLOT_BITS(32), .CLK_DIV(2)) dut_a (
        .clk(clk), .reset(reset), .enable(en_a), .in_valid(valid_a), .in_ready(ready_a),
        .in_left(l_a), .in_right(r_a), .sck(sck_a), .ws(ws_a), .sd(sd_a),
        .underrun(un_a), .busy(busy_a));

    pcm_to_i2s_tx #(.NUMBER_OF_BITS(16), .SLOT_BITS(17), .CLK_DIV(1)) dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .in_valid(valid_b), .in_ready(ready_b),
        .in_left(l_b), .in_right(r_b), .sck(sck_b), .ws(ws_b), .sd(sd_b),
        .underrun(un_b), .busy(busy_b));

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // ---------------- I2S receiver models (sample on sck rise) ----------------
    int          idx_a = 100, idx_b = 100;
    logic        pws_a = 1'b1, pws_b = 1'b1;
    logic [15:0] word_a, cur_l_a, word_b, cur_l_b;
    logic [31:0] frames_a[$];
    logic [31:0] frames_b[$];

    always @(posedge sck_a) begin
        if (ws_a != pws_a) idx_a = 0;
        else if (idx_a < 100) idx_a++;
        pws_a = ws_a;
        if (idx_a >= 1 && idx_a <= 16) begin
            word_a = {word_a[14:0], sd_a};
            if (idx_a == 16) begin
                if (!ws_a) cur_l_a = word_a;
                else frames_a.push_back({cur_l_a, word_a});
            end
        end else if (idx_a < 32) begin
            chk("pad_a", {31'd0, sd_a}, 32'd0);
        end
    end

    always @(posedge sck_b) begin
        if (ws_b != pws_b) idx_b = 0;
        else if (idx_b < 100) idx_b++;
        pws_b = ws_b;
        if (idx_b >= 1 && idx_b <= 16) begin
            word_b = {word_b[14:0], sd_b};
            if (idx_b == 16) begin
                if (!ws_b) cur_l_b = word_b;
                else frames_b.push_back({cur_l_b, word_b});
            end
        end else if (idx_b < 17) begin
            chk("delay_b", {31'd0, sd_b}, 32'd0);
        end
    end

    // ---------------- edge/timing monitors ----------------
    int   wsfall_a[$], wsfall_b[$], sckrise_a[$], sckrise_b[$];
    int   un_cnt_a = 0, un_cnt_b = 0;
    logic nws_a = 1, nws_b = 1, nsck_a = 0, nsck_b = 0, nun_a = 0, nun_b = 0;

    always @(negedge clk) begin
        if (nws_a && !ws_a) wsfall_a.push_back(cyc);
        if (nws_b && !ws_b) wsfall_b.push_back(cyc);
        if (!nsck_a && sck_a) sckrise_a.push_back(cyc);
        if (!nsck_b && sck_b) sckrise_b.push_back(cyc);
        if (un_a) begin
            un_cnt_a++;
            chk("underrun_a_at_ws_fall", {30'd0, nws_a, ws_a}, 32'd2);
            chk("underrun_a_width", {31'd0, nun_a}, 32'd0);
        end
        if (un_b) un_cnt_b++;
        nws_a = ws_a;  nws_b = ws_b;  nsck_a = sck_a;  nsck_b = sck_b;
        nun_a = un_a;  nun_b = un_b;
    end

    // ---------------- helpers ----------------
    function automatic logic sig(input int code);
        case (code)
            0: return ws_a;
            1: return busy_a;
            2: return ready_a;
            3: return busy_b;
            4: return ready_b;
            5: return (un_cnt_a >= 1);
            default: return 1'bx;
        endcase
    endfunction

    task automatic wait_for(input int code, input logic val, input int budget, input string name);
        int n = 0;
        while (sig(code) !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, sig(code)}, {31'd0, val});
    endtask

    task automatic send_pair(input bit which, input logic [15:0] l, input logic [15:0] r);
        int n = 0;
        if (!which) begin l_a = l; r_a = r; valid_a = 1; end
        else        begin l_b = l; r_b = r; valid_b = 1; end
        while ((which ? ready_b : ready_a) !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("send_ready", {31'd0, (which ? ready_b : ready_a)}, 32'd1);
        @(posedge clk); #1;
        valid_a = 0; valid_b = 0;
    endtask

    typedef struct {
        logic [15:0] l, r, exp_l, exp_r;
    } vec_t;
    vec_t vecs[24];

    initial begin
        for (int k = 0; k < 16; k++) begin
            vecs[k].l = 16'(k + 1);
            vecs[k].r = ~16'(k + 1);
        end
        for (int k = 16; k < 24; k++) begin
            vecs[k].l = 16'($urandom);
            vecs[k].r = 16'($urandom);
        end
        for (int k = 0; k < 24; k++) begin
            vecs[k].exp_l = vecs[k].l;
            vecs[k].exp_r = vecs[k].r;
        end

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("rst_sck", {31'd0, sck_a}, 32'd0);
        chk("rst_ws", {31'd0, ws_a}, 32'd1);
        chk("rst_sd", {31'd0, sd_a}, 32'd0);
        chk("rst_ready", {31'd0, ready_a}, 32'd1);
        chk("rst_underrun", {31'd0, un_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_ws_b", {31'd0, ws_b}, 32'd1);

        // ---- preload, single frame, enable dropped at bit_cnt 40 ----
        send_pair(0, 16'hA5C3, 16'h8001);
        @(negedge clk);
        chk("preload_ready_low", {31'd0, ready_a}, 32'd0);
        sckrise_a.delete();
        @(posedge clk); #1 en_a = 1;
        wait_for(0, 1'b0, 100, "t2_ws_fall");
        wait_for(0, 1'b1, 200, "t2_ws_rise");
        @(posedge clk);
        repeat (32) @(posedge clk);
        #1 en_a = 0;
        wait_for(1, 1'b0, 300, "t2_idle");
        chk("t2_nframes", frames_a.size(), 1);
        if (frames_a.size() >= 1) chk("t2_frame", frames_a[0], 32'hA5C3_8001);
        if (sckrise_a.size() >= 2) chk("t2_sck_period", sckrise_a[1] - sckrise_a[0], 4);
        else chk("t2_sck_rises", sckrise_a.size(), 2);
        sckrise_a.delete();
        repeat (20) @(negedge clk);
        chk("t2_idle_ws", {31'd0, ws_a}, 32'd1);
        chk("t2_idle_sck", {31'd0, sck_a}, 32'd0);
        chk("t2_idle_no_sck", sckrise_a.size(), 0);
        chk("t2_no_underrun", un_cnt_a, 0);

        // ---- back-to-back table + random pairs ----
        frames_a.delete();
        wsfall_a.delete();
        send_pair(0, vecs[0].l, vecs[0].r);
        en_a = 1;
        for (int k = 1; k < 24; k++) send_pair(0, vecs[k].l, vecs[k].r);
        wait_for(2, 1'b1, 400, "t3_last_unload");
        en_a = 0;
        wait_for(1, 1'b0, 400, "t3_idle");
        chk("t3_nframes", frames_a.size(), 24);
        for (int k = 0; k < 24 && k < frames_a.size(); k++)
            chk("t3_frame", frames_a[k], {vecs[k].exp_l, vecs[k].exp_r});
        chk("t3_no_underrun", un_cnt_a, 0);
        chk("t3_nwsfalls", wsfall_a.size(), 24);
        for (int k = 1; k < wsfall_a.size(); k++)
            chk("t3_frame_period", wsfall_a[k] - wsfall_a[k-1], 256);

        // ---- underrun after one frame ----
        frames_a.delete();
        send_pair(0, 16'h1234, 16'h5678);
        en_a = 1;
        wait_for(2, 1'b1, 100, "t4_unload");
        wait_for(5, 1'b1, 400, "t4_underrun_seen");
        en_a = 0;
        wait_for(1, 1'b0, 400, "t4_idle");
        chk("t4_nframes", frames_a.size(), 2);
        if (frames_a.size() >= 2) begin
            chk("t4_frame0", frames_a[0], 32'h1234_5678);
            chk("t4_frame1_silence", frames_a[1], 32'h0);
        end
        chk("t4_underrun_count", un_cnt_a, 1);

        // ---- reset mid-frame discards the queued pair ----
        send_pair(0, 16'hAAAA, 16'h5555);
        en_a = 1;
        wait_for(2, 1'b1, 100, "t5_unload");
        send_pair(0, 16'h1111, 16'h2222);
        @(negedge clk);
        chk("t5_queued", {31'd0, ready_a}, 32'd0);
        repeat (50) @(posedge clk);
        #1 reset = 1; en_a = 0;
        @(posedge clk); #1 reset = 0;
        @(negedge clk);
        chk("t5_sck", {31'd0, sck_a}, 32'd0);
        chk("t5_ws", {31'd0, ws_a}, 32'd1);
        chk("t5_sd", {31'd0, sd_a}, 32'd0);
        chk("t5_ready", {31'd0, ready_a}, 32'd1);
        chk("t5_busy", {31'd0, busy_a}, 32'd0);
        frames_a.delete();
        un_cnt_a = 0;
        en_a = 1;
        wait_for(5, 1'b1, 100, "t5_underrun_after_reset");
        en_a = 0;
        wait_for(1, 1'b0, 400, "t5_idle");
        chk("t5_nframes", frames_a.size(), 1);
        if (frames_a.size() >= 1) chk("t5_discarded", frames_a[0], 32'h0);

        // ---- CLK_DIV=1, SLOT_BITS=17 instance ----
        sckrise_b.delete();
        wsfall_b.delete();
        send_pair(1, 16'hFFFF, 16'h0000);
        en_b = 1;
        send_pair(1, 16'h0000, 16'hFFFF);
        wait_for(4, 1'b1, 200, "t6_unload");
        en_b = 0;
        wait_for(3, 1'b0, 200, "t6_idle");
        chk("t6_nframes", frames_b.size(), 2);
        if (frames_b.size() >= 2) begin
            chk("t6_frame0", frames_b[0], 32'hFFFF_0000);
            chk("t6_frame1", frames_b[1], 32'h0000_FFFF);
        end
        if (sckrise_b.size() >= 2) chk("t6_sck_period", sckrise_b[1] - sckrise_b[0], 2);
        else chk("t6_sck_rises", sckrise_b.size(), 2);
        if (wsfall_b.size() >= 2) chk("t6_frame_period", wsfall_b[1] - wsfall_b[0], 68);
        else chk("t6_nwsfalls", wsfall_b.size(), 2);
        chk("t6_no_underrun", un_cnt_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
